// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard / interrupt-entry controller: decode-stage stall, branch flush,
// drained trap entry. Define OTTER_FWD_EN to enable operand forwarding (load-use stalls only).
module pipe_hazard_ctrl #(
  parameter int CNT_W     = 32,
  parameter int DRAIN_CYC = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       dec_rs1_i,
  input  logic [4:0]       dec_rs2_i,
  input  logic             dec_use1_i,
  input  logic             dec_use2_i,
  input  logic [4:0]       ex_rd_i,
  input  logic [4:0]       mem_rd_i,
  input  logic [4:0]       wb_rd_i,
  input  logic             ex_regwr_i,
  input  logic             mem_regwr_i,
  input  logic             wb_regwr_i,
  input  logic             ex_load_i,
  input  logic             mem_load_i,
  input  logic             br_taken_i,
  input  logic             int_i,
  input  logic             mie_i,
  output logic             pc_write_o,
  output logic             dec_en_o,
  output logic             dec_flush_o,
  output logic             ex_bubble_o,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic             int_taken_o,
  output logic             trap_sel_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int DCW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYC - 1);

  typedef enum logic [1:0] {RUN, DRAIN, TRAP} state_e;

  state_e           state_q, state_d;
  logic [DCW-1:0]   drainCnt_q, drainCnt_d;
  logic [CNT_W-1:0] stallCnt_q, stallCnt_d;

  logic matchEx1, matchMem1, matchWb1;
  logic matchEx2, matchMem2, matchWb2;
  logic stall;
  logic [1:0] fwdA, fwdB;

  assign matchEx1  = dec_use1_i && ex_regwr_i  && (ex_rd_i  == dec_rs1_i) && (ex_rd_i  != 5'd0);
  assign matchMem1 = dec_use1_i && mem_regwr_i && (mem_rd_i == dec_rs1_i) && (mem_rd_i != 5'd0);
  assign matchWb1  = dec_use1_i && wb_regwr_i  && (wb_rd_i  == dec_rs1_i) && (wb_rd_i  != 5'd0);
  assign matchEx2  = dec_use2_i && ex_regwr_i  && (ex_rd_i  == dec_rs2_i) && (ex_rd_i  != 5'd0);
  assign matchMem2 = dec_use2_i && mem_regwr_i && (mem_rd_i == dec_rs2_i) && (mem_rd_i != 5'd0);
  assign matchWb2  = dec_use2_i && wb_regwr_i  && (wb_rd_i  == dec_rs2_i) && (wb_rd_i  != 5'd0);

`ifdef OTTER_FWD_EN
  // Only a load still in EX or MEM has no value to forward yet; youngest producer wins.
  assign stall = (matchEx1 && ex_load_i) || (matchMem1 && mem_load_i) ||
                 (matchEx2 && ex_load_i) || (matchMem2 && mem_load_i);
  assign fwdA  = matchEx1 ? 2'b01 : matchMem1 ? 2'b10 : matchWb1 ? 2'b11 : 2'b00;
  assign fwdB  = matchEx2 ? 2'b01 : matchMem2 ? 2'b10 : matchWb2 ? 2'b11 : 2'b00;
`else
  logic unusedLoads;
  assign unusedLoads = ex_load_i | mem_load_i;
  assign stall = matchEx1 || matchMem1 || matchWb1 || matchEx2 || matchMem2 || matchWb2;
  assign fwdA  = 2'b00;
  assign fwdB  = 2'b00;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= RUN;
      drainCnt_q <= '0;
      stallCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      drainCnt_q <= drainCnt_d;
      stallCnt_q <= stallCnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    drainCnt_d  = drainCnt_q;
    stallCnt_d  = stallCnt_q;
    pc_write_o  = 1'b0;
    dec_en_o    = 1'b0;
    dec_flush_o = 1'b1;
    ex_bubble_o = 1'b1;
    int_taken_o = 1'b0;
    trap_sel_o  = 1'b0;
    fwd_a_o     = 2'b00;
    fwd_b_o     = 2'b00;
    case (state_q)
      RUN: begin
        if (stall) begin
          dec_flush_o = 1'b0;
          if (stallCnt_q != '1) stallCnt_d = stallCnt_q + CNT_W'(1);
        end else begin
          pc_write_o  = 1'b1;
          dec_en_o    = 1'b1;
          ex_bubble_o = 1'b0;
          dec_flush_o = br_taken_i;
          fwd_a_o     = fwdA;
          fwd_b_o     = fwdB;
          if (!br_taken_i && int_i && mie_i) begin
            state_d    = DRAIN;
            drainCnt_d = '0;
          end
        end
      end
      // Once entered, the drain runs to completion regardless of INT/MIE.
      DRAIN: begin
        if (drainCnt_q == DRAIN_LAST) begin
          state_d    = TRAP;
          drainCnt_d = '0;
        end else begin
          drainCnt_d = drainCnt_q + DCW'(1);
        end
      end
      TRAP: begin
        int_taken_o = 1'b1;
        trap_sel_o  = 1'b1;
        pc_write_o  = 1'b1;
        dec_en_o    = 1'b1;
        state_d     = RUN;
      end
      default: state_d = RUN;
    endcase
    // Reset forces the pipeline frozen/flushed independent of the registered state.
    if (rst_i) begin
      pc_write_o  = 1'b0;
      dec_en_o    = 1'b0;
      dec_flush_o = 1'b1;
      ex_bubble_o = 1'b1;
      int_taken_o = 1'b0;
      trap_sel_o  = 1'b0;
      fwd_a_o     = 2'b00;
      fwd_b_o     = 2'b00;
    end
  end

  assign stall_cnt_o = stallCnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl; covers both OTTER_FWD_EN builds.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 4;

  // {pc_write, dec_en, dec_flush, ex_bubble, int_taken, trap_sel}
  localparam logic [5:0] C_RUN   = 6'b110000;
  localparam logic [5:0] C_STALL = 6'b000100;
  localparam logic [5:0] C_BR    = 6'b111000;
  localparam logic [5:0] C_DRAIN = 6'b001100;
  localparam logic [5:0] C_RST   = 6'b001100;
  // {pc_write, dec_flush, ex_bubble, int_taken, trap_sel}
  localparam logic [4:0] C_TRAP  = 5'b11111;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] decRs1, decRs2, exRd, memRd, wbRd;
  logic decUse1, decUse2, exRegwr, memRegwr, wbRegwr, exLoad, memLoad;
  logic brTaken, intReq, mie;
  logic pcWrite, decEn, decFlush, exBubble, intTaken, trapSel;
  logic [1:0] fwdA, fwdB;
  logic [CNT_W-1:0] stallCnt;

  int checks = 0;
  int errors = 0;
  int expCnt = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .DRAIN_CYC(3)) dut (
    .clk_i(clk), .rst_i(rst),
    .dec_rs1_i(decRs1), .dec_rs2_i(decRs2), .dec_use1_i(decUse1), .dec_use2_i(decUse2),
    .ex_rd_i(exRd), .mem_rd_i(memRd), .wb_rd_i(wbRd),
    .ex_regwr_i(exRegwr), .mem_regwr_i(memRegwr), .wb_regwr_i(wbRegwr),
    .ex_load_i(exLoad), .mem_load_i(memLoad),
    .br_taken_i(brTaken), .int_i(intReq), .mie_i(mie),
    .pc_write_o(pcWrite), .dec_en_o(decEn), .dec_flush_o(decFlush), .ex_bubble_o(exBubble),
    .fwd_a_o(fwdA), .fwd_b_o(fwdB), .int_taken_o(intTaken), .trap_sel_o(trapSel),
    .stall_cnt_o(stallCnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkCtrl(input string tag, input logic [5:0] exp);
    checkOutput(tag, {26'd0, pcWrite, decEn, decFlush, exBubble, intTaken, trapSel}, {26'd0, exp});
  endtask

  task automatic checkFwd(input string tag, input logic [1:0] a, input logic [1:0] b);
    checkOutput(tag, {28'd0, fwdA, fwdB}, {28'd0, a, b});
  endtask

  task automatic checkCnt(input string tag);
    checkOutput(tag, 32'(stallCnt), 32'(expCnt));
  endtask

  task automatic setStages(input logic [4:0] eRd, input logic eWr, input logic eLd,
                           input logic [4:0] mRd, input logic mWr, input logic mLd,
                           input logic [4:0] wRd, input logic wWr);
    exRd = eRd; exRegwr = eWr; exLoad = eLd;
    memRd = mRd; memRegwr = mWr; memLoad = mLd;
    wbRd = wRd; wbRegwr = wWr;
  endtask

  task automatic applyStimulus(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                               input logic u2, input logic br, input logic ir, input logic ie);
    decRs1 = rs1; decUse1 = u1; decRs2 = rs2; decUse2 = u2;
    brTaken = br; intReq = ir; mie = ie;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    setStages(0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    checkCtrl("reset_ctrl", C_RST);
    checkFwd("reset_fwd", 2'b00, 2'b00);
    checkCnt("reset_cnt");

    rst = 1'b0;
    #1;
    checkCtrl("first_run", C_RUN);

`ifdef OTTER_FWD_EN
    setStages(5, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(5, 1, 0, 0, 0, 0, 0);
    checkCtrl("fwd_ex_nostall", C_RUN);
    checkFwd("fwd_ex_a", 2'b01, 2'b00);
    tick();
    checkCnt("fwd_ex_cnt");
    setStages(5, 1, 1, 0, 0, 0, 0, 0);
    applyStimulus(5, 1, 0, 0, 0, 0, 0);
    checkCtrl("fwd_loaduse_stall", C_STALL);
    checkFwd("fwd_loaduse_fwd", 2'b00, 2'b00);
    tick();
    expCnt = 1;
    checkCnt("fwd_loaduse_cnt");
    setStages(0, 0, 0, 7, 1, 0, 7, 1);
    applyStimulus(0, 0, 7, 1, 0, 0, 0);
    checkCtrl("fwd_mem_wb_run", C_RUN);
    checkFwd("fwd_mem_over_wb", 2'b00, 2'b10);
    setStages(9, 1, 0, 9, 1, 0, 4, 1);
    applyStimulus(4, 1, 9, 1, 0, 0, 0);
    checkFwd("fwd_wb_a_ex_b", 2'b11, 2'b01);
    tick();
`else
    setStages(0, 0, 0, 0, 0, 0, 3, 1);
    applyStimulus(3, 1, 0, 0, 0, 0, 0);
    checkCtrl("wb_match_stall", C_STALL);
    checkFwd("wb_match_fwd", 2'b00, 2'b00);
    tick();
    expCnt = 1;
    checkCnt("wb_match_cnt1");
    checkCtrl("wb_match_stall2", C_STALL);
    tick();
    expCnt = 2;
    checkCnt("wb_match_cnt2");
    setStages(0, 0, 0, 9, 1, 0, 0, 0);
    applyStimulus(0, 0, 9, 1, 0, 0, 0);
    checkCtrl("mem_match_rs2_stall", C_STALL);
    tick();
    expCnt = 3;
    checkCnt("mem_match_cnt");
`endif

    setStages(0, 1, 0, 0, 1, 0, 0, 1);
    applyStimulus(0, 1, 0, 1, 0, 0, 0);
    checkCtrl("rd_zero_run", C_RUN);
    checkFwd("rd_zero_fwd", 2'b00, 2'b00);
    tick();
    checkCnt("rd_zero_cnt");

    setStages(6, 1, 1, 6, 1, 1, 6, 1);
    applyStimulus(6, 0, 6, 0, 0, 0, 0);
    checkCtrl("unused_src_run", C_RUN);

    setStages(0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkCtrl("branch_flush", C_BR);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkCtrl("branch_one_cycle", C_RUN);

    setStages(5, 1, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 5, 1, 1, 0, 0);
    checkCtrl("branch_vs_stall", C_STALL);
    tick();
    expCnt++;
    checkCnt("branch_vs_stall_cnt");

    applyStimulus(0, 0, 5, 1, 0, 1, 1);
    checkCtrl("int_blocked_by_stall", C_STALL);
    tick();
    expCnt++;
    setStages(0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkCtrl("int_not_taken", C_RUN);

    applyStimulus(0, 0, 0, 0, 0, 1, 1);
    checkCtrl("int_accept_cycle", C_RUN);
    tick();
    checkCtrl("drain1", C_DRAIN);
    checkFwd("drain1_fwd", 2'b00, 2'b00);
    setStages(5, 1, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 5, 1, 0, 1, 0);
    tick();
    checkCtrl("drain2_mie_low", C_DRAIN);
    tick();
    checkCtrl("drain3", C_DRAIN);
    tick();
    checkOutput("trap", {27'd0, pcWrite, decFlush, exBubble, intTaken, trapSel}, {27'd0, C_TRAP});
    checkCnt("drain_not_counted");
    setStages(0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick();
    checkCtrl("after_trap_run", C_RUN);

    applyStimulus(0, 0, 0, 0, 0, 1, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick();
    checkCtrl("drain2_before_rst", C_DRAIN);
    rst = 1'b1;
    #1;
    expCnt = 0;
    checkCtrl("rst_in_drain_ctrl", C_RST);
    checkCnt("rst_in_drain_cnt");
    tick();
    rst = 1'b0;
    #1;
    checkCtrl("post_rst_run", C_RUN);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkCtrl("no_trap_after_rst", C_RUN);
    end

    setStages(5, 1, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 5, 1, 0, 0, 0);
    repeat (3) tick();
    expCnt = 3;
    checkCnt("sat_partial");
    repeat (17) tick();
    expCnt = 15;
    checkCnt("sat_hold");
    checkCtrl("sat_stall", C_STALL);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter CNT_W, default 32: width of stall-cycle counter STALL_CNT.
REQ-002 Parameter DRAIN_CYC, default 3: cycles needed for EX/MEM/WB to retire before trap entry.
REQ-003 CLK  in  1  single clock; all state on rising edge.
REQ-004 RST  in  1  reset, asynchronous, active-high.
REQ-005 DEC_RS1, DEC_RS2  in  5 each  source register addresses of instruction in decode.
REQ-006 DEC_USE1, DEC_USE2  in  1 each  decode instruction actually reads RS1/RS2.
REQ-007 EX_RD, MEM_RD, WB_RD  in  5 each  destination register per stage.
REQ-008 EX_REGWR, MEM_REGWR, WB_REGWR  in  1 each  stage instruction writes register file.
REQ-009 EX_LOAD, MEM_LOAD  in  1 each  stage instruction is a load.
REQ-010 BR_TAKEN  in  1  decode-resolved jump/branch/jalr redirect.
REQ-011 INT, MIE  in  1 each  external interrupt level; interrupt enable.
REQ-012 PC_WRITE, DEC_EN  out  1 each  PC and decode-register (IR/PC) enables.
REQ-013 DEC_FLUSH, EX_BUBBLE  out  1 each  null decode IR; inject NOP into execute.
REQ-014 FWD_A, FWD_B  out  2 each  operand source: 00 regfile, 01 EX ALU, 10 MEM result, 11 WB data.
REQ-015 INT_TAKEN, TRAP_SEL  out  1 each  one-cycle trap pulse to CSR; PC mux selects mtvec.
REQ-016 STALL_CNT  out  CNT_W  saturating count of stall cycles.

Function
REQ-017 A source "matches" a stage when DEC_USEn=1, stage REGWR=1, stage RD equals DEC_RSn, and RD!=0.
REQ-018 States: RUN, DRAIN, TRAP; encoding is free.
REQ-019 RUN, no stall, no redirect: PC_WRITE=1, DEC_EN=1, DEC_FLUSH=0, EX_BUBBLE=0.
REQ-020 Stall (RUN): PC_WRITE=0, DEC_EN=0, EX_BUBBLE=1, DEC_FLUSH=0; stall and outputs are combinational in the same cycle.
REQ-021 BR_TAKEN in RUN without stall: PC_WRITE=1, DEC_EN=1, DEC_FLUSH=1 for exactly that cycle.
REQ-022 Stall and BR_TAKEN together: stall wins, BR_TAKEN ignored that cycle.
REQ-023 Interrupt accepted in RUN only when INT&MIE=1 and neither stall nor BR_TAKEN; next state DRAIN.
REQ-024 DRAIN: PC_WRITE=0, DEC_EN=0, DEC_FLUSH=1, EX_BUBBLE=1 for DRAIN_CYC cycles (internal counter), then TRAP.
REQ-025 MIE or INT dropping during DRAIN does not abort; entry is committed.
REQ-026 TRAP lasts one cycle: INT_TAKEN=1, TRAP_SEL=1, PC_WRITE=1, DEC_FLUSH=1, EX_BUBBLE=1; next state RUN.
REQ-027 INT_TAKEN and TRAP_SEL are 0 in every state other than TRAP.
REQ-028 STALL_CNT increments by 1 each RUN-state stall cycle; holds at all-ones; DRAIN/TRAP cycles not counted.
REQ-029 FWD_A/FWD_B are 00 outside RUN and in any stall cycle.

Reset
REQ-030 While RST=1: state RUN, drain counter 0, STALL_CNT 0, PC_WRITE=0, DEC_EN=0, DEC_FLUSH=1, EX_BUBBLE=1, INT_TAKEN=0, TRAP_SEL=0, FWD_A=FWD_B=00.
REQ-031 RST during DRAIN or TRAP abandons the trap; no INT_TAKEN pulse after release.
REQ-032 First cycle after RST falls behaves as RUN per REQ-019..023.

Configuration
REQ-033 Macro OTTER_FWD_EN defined: stall only if a source matches EX with EX_LOAD=1 or MEM with MEM_LOAD=1; otherwise FWD selects the youngest match with priority EX(01) > MEM(10) > WB(11), else 00.
REQ-034 OTTER_FWD_EN undefined: stall on any match in EX, MEM or WB; FWD_A=FWD_B=00 always.

Verification
REQ-035 FWD_EN: EX_RD=5,EX_REGWR=1,DEC_RS1=5,DEC_USE1=1 -> FWD_A=01, no stall; same with EX_LOAD=1 -> PC_WRITE=0, EX_BUBBLE=1, STALL_CNT +1.
REQ-036 FWD_EN: DEC_RS2=7 matches MEM and WB -> FWD_B=10; RD=0 in all stages with REGWR=1 -> FWD 00, no stall.
REQ-037 No FWD_EN: WB_RD=3,WB_REGWR=1,DEC_RS1=3 -> stall for each matching cycle, FWD_A=00.
REQ-038 BR_TAKEN=1 alone -> DEC_FLUSH=1, PC_WRITE=1 one cycle; BR_TAKEN with load-use stall -> DEC_FLUSH=0, PC_WRITE=0.
REQ-039 INT=1,MIE=1 in RUN -> 3 DRAIN cycles (PC_WRITE=0, EX_BUBBLE=1), then one cycle INT_TAKEN=1,TRAP_SEL=1,PC_WRITE=1, then RUN; drop MIE mid-drain -> same sequence.
REQ-040 Assert RST in 2nd DRAIN cycle -> outputs per REQ-030, STALL_CNT=0, no INT_TAKEN after release with INT=0.
